// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: program-memory port plus the decoder-facing instruction stream.
// The master side is the fetch unit; the slave side is memory, decoder and control.
interface fetch_unit_if #(
    parameter int PMEM_ADDR_WIDTH = 12,
    parameter int PMEM_WORD_WIDTH = 16,
    parameter int PC_WIDTH        = 12
);
    logic                       in_jump;
    logic [PC_WIDTH-1:0]        in_jump_target;
    logic                       in_stall;
    logic [PMEM_WORD_WIDTH-1:0] in_pmem_data;
    logic [PMEM_ADDR_WIDTH-1:0] out_pmem_addr;
    logic [PMEM_WORD_WIDTH-1:0] out_instr;
    logic [PC_WIDTH-1:0]        out_pc;
    logic                       out_valid;
    logic                       out_flush;

    modport master (
        input  in_jump, in_jump_target, in_stall, in_pmem_data,
        output out_pmem_addr, out_instr, out_pc, out_valid, out_flush
    );

    modport slave (
        output in_jump, in_jump_target, in_stall, in_pmem_data,
        input  out_pmem_addr, out_instr, out_pc, out_valid, out_flush
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential fetch with jump redirects (one flush bubble)
// and decoder stalls that freeze the presented instruction.
module fetch_unit #(
    parameter int                    PMEM_ADDR_WIDTH = 12,
    parameter int                    PMEM_WORD_WIDTH = 16,
    parameter int                    PC_WIDTH        = 12,
    parameter logic [PC_WIDTH-1:0]   RESET_PC        = '0
) (
    input  logic          clock,
    input  logic          reset,
    fetch_unit_if.master  bus
);
    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        STALL    = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    state_t                     state_reg, state_next;
    logic [PC_WIDTH-1:0]        pc_fetch_reg, pc_fetch_next;
    logic [PC_WIDTH-1:0]        pc_q_reg, pc_q_next;
    logic [PMEM_WORD_WIDTH-1:0] instr_hold_reg, instr_hold_next;
    logic [PMEM_WORD_WIDTH-1:0] instr_mux;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg      <= BOOT;
            pc_fetch_reg   <= RESET_PC;
            pc_q_reg       <= RESET_PC;
            instr_hold_reg <= '0;
        end else begin
            state_reg      <= state_next;
            pc_fetch_reg   <= pc_fetch_next;
            pc_q_reg       <= pc_q_next;
            instr_hold_reg <= instr_hold_next;
        end
    end

    // Jump beats stall; stall only applies while a real instruction is presented.
    always_comb begin
        state_next    = state_reg;
        pc_fetch_next = pc_fetch_reg;
        pc_q_next     = pc_q_reg;
        if (bus.in_jump) begin
            pc_fetch_next = bus.in_jump_target;
            state_next    = REDIRECT;
        end else if (bus.in_stall && (state_reg == RUN || state_reg == STALL)) begin
            state_next    = STALL;
        end else begin
            pc_q_next     = pc_fetch_reg;
            pc_fetch_next = pc_fetch_reg + PC_ONE;
            state_next    = RUN;
        end
    end

    always_comb begin
        instr_mux = '0;
        case (state_reg)
            RUN:     instr_mux = bus.in_pmem_data;
            STALL:   instr_mux = instr_hold_reg;
            default: instr_mux = '0;
        endcase
    end

    // The hold register tracks the presented word until a stall freezes it.
    assign instr_hold_next = (state_reg == STALL) ? instr_hold_reg : instr_mux;

    assign bus.out_pmem_addr = pc_fetch_reg[PMEM_ADDR_WIDTH-1:0];
    assign bus.out_instr     = instr_mux;
    assign bus.out_pc        = pc_q_reg;
    assign bus.out_valid     = (state_reg == RUN) || (state_reg == STALL);
    assign bus.out_flush     = (state_reg == BOOT) || (state_reg == REDIRECT);
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a vector table for boot, jump and stall, then hand
// sequences for jump-during-stall, PC wrap and reset during a redirect.
module tb_fetch_unit;
    localparam int AW = 12;
    localparam int DW = 16;
    localparam int PW = 12;

    logic clock = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cycle_no = 0;

    logic [DW-1:0] mem [4096];

    fetch_unit_if #(.PMEM_ADDR_WIDTH(AW), .PMEM_WORD_WIDTH(DW), .PC_WIDTH(PW)) bus ();

    fetch_unit #(
        .PMEM_ADDR_WIDTH(AW),
        .PMEM_WORD_WIDTH(DW),
        .PC_WIDTH(PW),
        .RESET_PC(12'h000)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    // Synchronous program memory, one cycle of read latency.
    always_ff @(posedge clock) begin
        bus.in_pmem_data <= mem[bus.out_pmem_addr];
    end

    typedef struct {
        logic          rst_n;
        logic          jump;
        logic [PW-1:0] target;
        logic          stall;
        logic          valid;
        logic          flush;
        logic [PW-1:0] pc;
        logic [AW-1:0] addr;
    } vec_t;

    vec_t vecs [19];

    function automatic vec_t mk(input logic rst_n, input logic jump, input logic [PW-1:0] target,
                                input logic stall, input logic valid, input logic flush,
                                input logic [PW-1:0] pc, input logic [AW-1:0] addr);
        vec_t v;
        v.rst_n = rst_n; v.jump = jump; v.target = target; v.stall = stall;
        v.valid = valid; v.flush = flush; v.pc = pc; v.addr = addr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs, compare this cycle's outputs, then advance past the edge.
    task automatic step(input string tag, input vec_t v);
        logic [DW-1:0] exp_instr;
        reset              = v.rst_n;
        bus.in_jump        = v.jump;
        bus.in_jump_target = v.target;
        bus.in_stall       = v.stall;
        exp_instr = v.valid ? (16'hA000 + {4'h0, v.pc}) : 16'h0000;
        $display("cycle %0d %s: rst_n=%0b jump=%0b stall=%0b -> valid=%0b flush=%0b pc=%03h instr=%04h addr=%03h",
                 cycle_no, tag, v.rst_n, v.jump, v.stall, bus.out_valid, bus.out_flush,
                 bus.out_pc, bus.out_instr, bus.out_pmem_addr);
        check({tag, " valid"}, {31'd0, bus.out_valid}, {31'd0, v.valid});
        check({tag, " flush"}, {31'd0, bus.out_flush}, {31'd0, v.flush});
        check({tag, " pc"},    {20'd0, bus.out_pc},    {20'd0, v.pc});
        check({tag, " instr"}, {16'd0, bus.out_instr}, {16'd0, exp_instr});
        check({tag, " addr"},  {20'd0, bus.out_pmem_addr}, {20'd0, v.addr});
        @(posedge clock);
        #1;
        cycle_no++;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'hA000 + 16'(i);

        //            rst jmp target  stl  vld flu pc      addr
        vecs[0]  = mk(0, 0, 12'h000, 0,   0, 1, 12'h000, 12'h000); // in reset
        vecs[1]  = mk(0, 0, 12'h000, 0,   0, 1, 12'h000, 12'h000);
        vecs[2]  = mk(1, 0, 12'h000, 1,   0, 1, 12'h000, 12'h000); // BOOT, stall ignored
        vecs[3]  = mk(1, 0, 12'h000, 0,   1, 0, 12'h000, 12'h001);
        vecs[4]  = mk(1, 0, 12'h000, 0,   1, 0, 12'h001, 12'h002);
        vecs[5]  = mk(1, 0, 12'h000, 0,   1, 0, 12'h002, 12'h003);
        vecs[6]  = mk(1, 0, 12'h000, 0,   1, 0, 12'h003, 12'h004);
        vecs[7]  = mk(1, 0, 12'h000, 0,   1, 0, 12'h004, 12'h005);
        vecs[8]  = mk(1, 1, 12'h100, 0,   1, 0, 12'h005, 12'h006); // jump to 0x100
        vecs[9]  = mk(1, 0, 12'h000, 0,   0, 1, 12'h005, 12'h100); // bubble
        vecs[10] = mk(1, 0, 12'h000, 0,   1, 0, 12'h100, 12'h101);
        vecs[11] = mk(1, 1, 12'h007, 0,   1, 0, 12'h101, 12'h102); // jump to 7
        vecs[12] = mk(1, 0, 12'h000, 1,   0, 1, 12'h101, 12'h007); // REDIRECT, stall ignored
        vecs[13] = mk(1, 0, 12'h000, 1,   1, 0, 12'h007, 12'h008); // stall 3 cycles
        vecs[14] = mk(1, 0, 12'h000, 1,   1, 0, 12'h007, 12'h008);
        vecs[15] = mk(1, 0, 12'h000, 1,   1, 0, 12'h007, 12'h008);
        vecs[16] = mk(1, 0, 12'h000, 0,   1, 0, 12'h007, 12'h008);
        vecs[17] = mk(1, 0, 12'h000, 0,   1, 0, 12'h008, 12'h009);
        vecs[18] = mk(1, 0, 12'h000, 0,   1, 0, 12'h009, 12'h00A);

        reset              = 1'b0;
        bus.in_jump        = 1'b0;
        bus.in_jump_target = '0;
        bus.in_stall       = 1'b0;
        @(posedge clock);
        #1;

        for (int i = 0; i < 19; i++) step($sformatf("vec%0d", i), vecs[i]);

        // Jump while stalled: stall stays high through the redirect.
        step("jstall0", mk(1, 0, 12'h000, 1, 1, 0, 12'h00A, 12'h00B));
        step("jstall1", mk(1, 1, 12'h020, 1, 1, 0, 12'h00A, 12'h00B));
        step("jstall2", mk(1, 0, 12'h000, 1, 0, 1, 12'h00A, 12'h020));
        step("jstall3", mk(1, 0, 12'h000, 1, 1, 0, 12'h020, 12'h021));
        step("jstall4", mk(1, 0, 12'h000, 0, 1, 0, 12'h020, 12'h021));

        // Wrap across the top of the address space.
        step("wrap0", mk(1, 1, 12'hFFE, 0, 1, 0, 12'h021, 12'h022));
        step("wrap1", mk(1, 0, 12'h000, 0, 0, 1, 12'h021, 12'hFFE));
        step("wrap2", mk(1, 0, 12'h000, 0, 1, 0, 12'hFFE, 12'hFFF));
        step("wrap3", mk(1, 0, 12'h000, 0, 1, 0, 12'hFFF, 12'h000));
        step("wrap4", mk(1, 0, 12'h000, 0, 1, 0, 12'h000, 12'h001));
        step("wrap5", mk(1, 0, 12'h000, 0, 1, 0, 12'h001, 12'h002));

        // Reset lands on the redirect cycle; target 0x300 must never be delivered.
        step("rstred0", mk(1, 1, 12'h300, 0, 1, 0, 12'h002, 12'h003));
        step("rstred1", mk(0, 0, 12'h000, 0, 0, 1, 12'h002, 12'h300));
        step("rstred2", mk(1, 0, 12'h000, 0, 0, 1, 12'h000, 12'h000));
        step("rstred3", mk(1, 0, 12'h000, 0, 1, 0, 12'h000, 12'h001));
        step("rstred4", mk(1, 0, 12'h000, 0, 1, 0, 12'h001, 12'h002));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
